// File: rtl/pocfail_brkreq.sv
// POC / target-reset failure break requester: filters the two fail flags,
// raises one acknowledged break request per qualified event, and keeps cause/count history.
module pocfail_brkreq #(
  parameter int DEB_CYC = 4,
  parameter int TMO_W   = 10,
  parameter int CNT_W   = 8
) (
  input  logic             CLK60MHZ,
  input  logic             pocrflclr,
  input  logic             BRKFAIL14,
  input  logic             TARRFL,
  input  logic             SVMODUSER,
  input  logic             ICEMSKPOC,
  input  logic             BRKACK,
  output logic             BRKREQ,
  output logic [1:0]       BRKCAUSE,
  output logic [CNT_W-1:0] FAILCNT,
  output logic             TIMEOUT,
  output logic             BUSY
);

  // state | meaning
  // IDLE  | waiting for a flag rise while in user mode
  // QUAL  | flag high, counting stable cycles
  // REQ   | break request raised, waiting for ack or timeout
  // ACKW  | ack seen, waiting for the break unit to release it
  typedef enum logic [1:0] {IDLE, QUAL, REQ, ACKW} state_t;

  localparam logic [3:0]       DEB_LAST = 4'(DEB_CYC - 1);
  localparam logic [3:0]       DEB_ONE  = 4'd1;
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             usr_s1, usr_s2;
  logic [1:0]       flags;
  logic             any_d;
  logic [3:0]       deb_cnt, deb_nxt;
  logic [1:0]       pend, pend_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             req_nxt, tmo_flag_nxt, fire;
  logic [1:0]       cause_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             any, rise, usr;

  // Flags are registered once so every output stays a pure register stage.
  assign any  = |flags;
  assign rise = any & ~any_d;
  assign usr  = usr_s2;

  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      usr_s1 <= 1'b0;
      usr_s2 <= 1'b0;
      flags  <= 2'b00;
      any_d  <= 1'b0;
    end else begin
      usr_s1 <= SVMODUSER;
      usr_s2 <= usr_s1;
      flags  <= {BRKFAIL14 & ~ICEMSKPOC, TARRFL};
      any_d  <= any;
    end
  end

  always_ff @(posedge CLK60MHZ or posedge pocrflclr) begin
    if (pocrflclr) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      pend     <= 2'b00;
      tmo_cnt  <= '0;
      BRKREQ   <= 1'b0;
      BRKCAUSE <= 2'b00;
      FAILCNT  <= '0;
      TIMEOUT  <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      pend     <= pend_nxt;
      tmo_cnt  <= tmo_nxt;
      BRKREQ   <= req_nxt;
      BRKCAUSE <= cause_nxt;
      FAILCNT  <= cnt_nxt;
      TIMEOUT  <= tmo_flag_nxt;
      BUSY     <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt    = state;
    deb_nxt      = deb_cnt;
    pend_nxt     = pend;
    tmo_nxt      = tmo_cnt;
    req_nxt      = BRKREQ;
    cause_nxt    = BRKCAUSE;
    cnt_nxt      = FAILCNT;
    tmo_flag_nxt = TIMEOUT;
    fire         = 1'b0;

    case (state)
      IDLE: begin
        if (rise && usr) begin
          deb_nxt  = DEB_ONE;
          pend_nxt = flags;
          // A one-cycle filter qualifies on the rise itself.
          if (DEB_CYC == 1) fire = 1'b1;
          else              state_nxt = QUAL;
        end
      end
      QUAL: begin
        pend_nxt = pend | flags;
        if (!any || !usr) begin
          state_nxt = IDLE;
          pend_nxt  = 2'b00;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          fire = 1'b1;
        end else begin
          deb_nxt = deb_cnt + DEB_ONE;
        end
      end
      REQ: begin
        cause_nxt = BRKCAUSE | flags;
        // Ack has priority over a same-cycle expiry.
        if (BRKACK) begin
          req_nxt   = 1'b0;
          state_nxt = ACKW;
        end else if (&tmo_cnt) begin
          req_nxt      = 1'b0;
          tmo_flag_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + TMO_ONE;
        end
      end
      ACKW: begin
        if (!BRKACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (fire) begin
      state_nxt = REQ;
      req_nxt   = 1'b1;
      cause_nxt = BRKCAUSE | pend_nxt;
      cnt_nxt   = (&FAILCNT) ? FAILCNT : FAILCNT + CNT_ONE;
      tmo_nxt   = '0;
      deb_nxt   = '0;
      pend_nxt  = 2'b00;
    end
  end

endmodule

// File: tb/tb_pocfail_brkreq.sv
// Bench for pocfail_brkreq: directed scenarios plus random traffic, all checked
// every cycle against an event-level model of the request behaviour.
module tb_pocfail_brkreq;
  localparam int DEB     = 4;
  localparam int TW      = 10;
  localparam int CW      = 8;
  localparam int TMO_LEN = 1 << TW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, brkfail, tarrfl, svmod, icemsk;
  logic ack_man, auto_ack, ack_follow;
  logic brkack;
  logic brkreq, timeout, busy;
  logic [1:0] brkcause;
  logic [CW-1:0] failcnt;

  int checks = 0;
  int failures = 0;

  assign brkack = auto_ack ? ack_follow : ack_man;

  pocfail_brkreq #(.DEB_CYC(DEB), .TMO_W(TW), .CNT_W(CW)) dut (
    .CLK60MHZ (clk),
    .pocrflclr(rst),
    .BRKFAIL14(brkfail),
    .TARRFL   (tarrfl),
    .SVMODUSER(svmod),
    .ICEMSKPOC(icemsk),
    .BRKACK   (brkack),
    .BRKREQ   (brkreq),
    .BRKCAUSE (brkcause),
    .FAILCNT  (failcnt),
    .TIMEOUT  (timeout),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  // Break unit stand-in: acknowledges whatever request it sees.
  always @(negedge clk) ack_follow <= brkreq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: flags are seen one cycle after the pins, user mode two.
  logic [1:0] m_seen, m_pend, m_cause;
  logic m_any_d, m_u1, m_u2, m_qual, m_req, m_hold, m_tmo;
  int m_run, m_age, m_cnt;

  task automatic m_fire();
    m_qual  = 1'b0;
    m_req   = 1'b1;
    m_age   = 0;
    m_cause = m_cause | m_pend;
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  always @(posedge clk or posedge rst) begin : model
    logic [1:0] f;
    logic a, u, rose;
    if (rst) begin
      m_seen = 0; m_pend = 0; m_cause = 0; m_any_d = 0; m_u1 = 0; m_u2 = 0;
      m_qual = 0; m_req = 0; m_hold = 0; m_tmo = 0; m_run = 0; m_age = 0; m_cnt = 0;
    end else begin
      f = m_seen;
      a = |f;
      u = m_u2;
      rose = a && !m_any_d;
      if (m_req) begin
        m_cause = m_cause | f;
        if (brkack) begin
          m_req = 0; m_hold = 1;
        end else if (m_age == TMO_LEN - 1) begin
          m_req = 0; m_tmo = 1;
        end else m_age++;
      end else if (m_hold) begin
        if (!brkack) m_hold = 0;
      end else if (m_qual) begin
        m_pend = m_pend | f;
        if (!a || !u) m_qual = 0;
        else begin
          m_run++;
          if (m_run >= DEB) m_fire();
        end
      end else if (rose && u) begin
        m_qual = 1; m_run = 1; m_pend = f;
        if (m_run >= DEB) m_fire();
      end
      m_any_d = a;
      m_seen  = {brkfail & ~icemsk, tarrfl};
      m_u2    = m_u1;
      m_u1    = svmod;
    end
  end

  always @(negedge clk) begin
    check("brkreq", brkreq, m_req);
    check("brkcause", brkcause, m_cause);
    check("failcnt", failcnt, m_cnt);
    check("timeout", timeout, m_tmo);
    check("busy", busy, m_qual | m_req | m_hold);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic wait_req(input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (brkreq) begin ok = 1; break; end
      @(negedge clk);
    end
    check(name, ok, 1);
  endtask

  initial begin
    int lat, len;
    bit saw;
    rst = 1'b1; brkfail = 0; tarrfl = 0; svmod = 0; icemsk = 0;
    ack_man = 0; auto_ack = 0;
    cyc(2);
    check("rst_brkreq", brkreq, 0);
    check("rst_failcnt", failcnt, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    svmod = 1'b1;
    cyc(4);

    // POC flag held, ack three cycles into the request
    brkfail = 1'b1;
    lat = 0;
    while (!brkreq && lat < 50) begin @(negedge clk); lat++; end
    check("t1_latency", lat, DEB + 1);
    len = 0;
    while (brkreq && len < 20) begin
      if (len == 2) ack_man = 1'b1;
      @(negedge clk);
      len++;
    end
    check("t1_req_len", len, 3);
    cyc(2);
    ack_man = 1'b0;
    brkfail = 1'b0;
    cyc(3);
    check("t1_cause", brkcause, 2'b10);
    check("t1_cnt", failcnt, 1);
    check("t1_tmo", timeout, 0);

    // Too-short target-reset pulse
    do_reset();
    tarrfl = 1'b1; cyc(3); tarrfl = 1'b0;
    saw = 0;
    repeat (10) begin @(negedge clk); if (brkreq) saw = 1; end
    check("t2_no_req", saw, 0);
    check("t2_cnt", failcnt, 0);
    check("t2_cause", brkcause, 0);
    check("t2_busy", busy, 0);

    // Both flags together, no ack: timeout
    do_reset();
    brkfail = 1'b1; tarrfl = 1'b1;
    wait_req("t3_req");
    len = 0;
    while (brkreq && len < 2000) begin @(negedge clk); len++; end
    check("t3_req_len", len, TMO_LEN);
    check("t3_tmo", timeout, 1);
    check("t3_cause", brkcause, 2'b11);
    check("t3_cnt", failcnt, 1);
    brkfail = 0; tarrfl = 0;

    // Ack on the very last timeout cycle wins
    do_reset();
    tarrfl = 1'b1;
    wait_req("t4_req");
    cyc(TMO_LEN - 1);
    ack_man = 1'b1;
    @(negedge clk);
    check("t4_req_drop", brkreq, 0);
    check("t4_tmo", timeout, 0);
    check("t4_busy_ackw", busy, 1);
    cyc(4);
    check("t4_busy_hold", busy, 1);
    ack_man = 1'b0;
    @(negedge clk);
    check("t4_idle", busy, 0);
    tarrfl = 1'b0;

    // Masked POC, then counter saturation
    do_reset();
    icemsk = 1'b1;
    repeat (3) begin brkfail = 1; cyc(8); brkfail = 0; cyc(2); end
    check("t5_masked_cnt", failcnt, 0);
    icemsk = 1'b0;
    auto_ack = 1'b1;
    repeat (300) begin tarrfl = 1; cyc(7); tarrfl = 0; cyc(3); end
    check("t5_sat", failcnt, CNT_MAX);
    auto_ack = 1'b0;

    // Reset during an active request, flag kept high
    do_reset();
    tarrfl = 1'b1;
    wait_req("t6_req");
    cyc(2);
    #2 rst = 1'b1;
    #1;
    check("t6_req_async", brkreq, 0);
    check("t6_cnt_async", failcnt, 0);
    check("t6_cause_async", brkcause, 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (20) begin @(negedge clk); if (brkreq || busy) saw = 1; end
    check("t6_no_restart", saw, 0);
    tarrfl = 1'b0; cyc(2); tarrfl = 1'b1;
    wait_req("t6_new_rise");
    ack_man = 1'b1; cyc(2); ack_man = 1'b0; tarrfl = 1'b0; cyc(3);

    // Random traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) brkfail = ~brkfail;
      if ($urandom_range(0, 7) == 0) tarrfl = ~tarrfl;
      if ($urandom_range(0, 39) == 0) svmod = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 59) == 0) icemsk = ~icemsk;
      if ($urandom_range(0, 4) == 0) ack_man = ~ack_man;
      if ($urandom_range(0, 1499) == 0) begin #2 rst = 1'b1; #2 rst = 1'b0; end
    end

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
